// File: rtl/mem_wb_bridge_if.sv
// Wishbone slave port plus byte-wide memory port of mem_wb_bridge.
interface mem_wb_bridge_if #(
  parameter int unsigned MEM_AW = 14
) ();
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [15:0]       wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o;
  logic              wb_err_o;
  logic [MEM_AW-1:0] mem_adr;
  logic [7:0]        mem_dat_o;
  logic [7:0]        mem_dat_i;
  logic              mem_en;
  logic              mem_we;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, mem_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, mem_adr, mem_dat_o, mem_en, mem_we
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, mem_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, mem_adr, mem_dat_o, mem_en, mem_we
  );
endinterface

// File: rtl/mem_wb_bridge.sv
// 32-bit Wishbone slave onto a byte-wide synchronous memory, one lane per cycle.
// Optional MEM_WB_BRIDGE_ERR_EN: out-of-range address or empty sel terminates with wb_err_o.
module mem_wb_bridge #(
  parameter int unsigned MEM_AW     = 14,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_bridge_if.slave bus
);

  localparam int unsigned WAW = MEM_AW - 2;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, TERM} state_t;

  state_t            state_q, state_d;
  logic [WAW-1:0]    adr_q, adr_d;
  logic              we_q, we_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_adr_q, mem_adr_d;
  logic [7:0]        mem_dat_q, mem_dat_d;
  logic              cap_q, cap_d;
  logic [1:0]        cap_off_q, cap_off_d;
  logic [31:0]       rdat_q, rdat_d;

  logic              req_c;
  logic              issue_c;
  logic [3:0]        issue_mask_c;
  logic [3:0]        sel_mask_c;
  logic [1:0]        issue_off_c;
  logic              unused_adr_bits;

  // Byte offset within the word -> data lane index of wb_dat.
  function automatic logic [1:0] lane_of(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  // Re-order the lane selects into byte-offset order.
  function automatic logic [3:0] sel_to_offsets(input logic [3:0] sel);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = sel[lane_of(2'(i))];
    return m;
  endfunction

  function automatic logic [1:0] lowest_off(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

`ifdef MEM_WB_BRIDGE_ERR_EN
  logic adr_bad_c;
  assign adr_bad_c = (bus.wb_adr_i >> MEM_AW) != 16'd0;
`endif

  assign unused_adr_bits = ^{bus.wb_adr_i[1:0], bus.wb_adr_i >> MEM_AW};

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    we_d         = we_q;
    dat_d        = dat_q;
    pend_d       = pend_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_adr_d    = mem_adr_q;
    mem_dat_d    = mem_dat_q;
    cap_d        = mem_en_q & ~mem_we_q;
    cap_off_d    = mem_adr_q[1:0];
    rdat_d       = rdat_q;
    issue_c      = 1'b0;
    issue_mask_c = pend_q;
    issue_off_c  = 2'd0;
    sel_mask_c   = sel_to_offsets(bus.wb_sel_i);
    req_c        = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q & ~err_q;

    // Read byte returns one cycle after its issue.
    if (cap_q && (state_q == XFER || state_q == DRAIN))
      rdat_d[{lane_of(cap_off_q), 3'b000} +: 8] = bus.mem_dat_i;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          adr_d = bus.wb_adr_i[MEM_AW-1:2];
          we_d  = bus.wb_we_i;
          dat_d = bus.wb_dat_i;
          if (!bus.wb_we_i) rdat_d = '0;
`ifdef MEM_WB_BRIDGE_ERR_EN
          if (adr_bad_c || bus.wb_sel_i == 4'h0) begin
            state_d = TERM;
            err_d   = 1'b1;
          end else
`endif
          if (sel_mask_c == 4'h0) begin
            state_d = TERM;
            ack_d   = 1'b1;
          end else begin
            state_d      = XFER;
            issue_c      = 1'b1;
            issue_mask_c = sel_mask_c;
          end
        end
      end
      XFER: begin
        if (!bus.wb_cyc_i) begin
          state_d = IDLE;
        end else if (pend_q != 4'h0) begin
          issue_c = 1'b1;
        end else if (we_q) begin
          state_d = TERM;
          ack_d   = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = TERM;
          ack_d   = 1'b1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Put the lowest pending byte offset on the memory port next cycle.
    if (issue_c) begin
      issue_off_c = lowest_off(issue_mask_c);
      pend_d      = issue_mask_c & ~(4'b0001 << issue_off_c);
      mem_en_d    = 1'b1;
      mem_we_d    = we_d;
      mem_adr_d   = {adr_d, issue_off_c};
      if (we_d) mem_dat_d = dat_d[{lane_of(issue_off_c), 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      pend_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      cap_q     <= 1'b0;
      cap_off_q <= '0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mem_en_q  <= mem_en_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
      cap_q     <= cap_d;
      cap_off_q <= cap_off_d;
      rdat_q    <= rdat_d;
    end
  end

  assign bus.wb_dat_o  = rdat_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_dat_o = mem_dat_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_wb_bridge.sv
// Bench for mem_wb_bridge: directed vector table, multi-cycle corner sequences, random vs model.
module tb_mem_wb_bridge;

  localparam int unsigned AW    = 14;
  localparam int unsigned MEMSZ = 1 << AW;
  localparam bit          BE    = 1'b1;
  localparam int          NVEC  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_wb_bridge_if #(.MEM_AW(AW)) bus ();

  mem_wb_bridge #(.MEM_AW(AW), .BIG_ENDIAN(BE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]    mem     [0:MEMSZ-1] = '{default: 8'h00};
  logic [7:0]    ref_mem [0:MEMSZ-1] = '{default: 8'h00};
  logic [AW-1:0] iss_q[$];
  logic [AW-1:0] exp_iss[$];
  int            n_checks = 0;
  int            n_err    = 0;

  // Byte-wide synchronous memory: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_dat_o;
      else            bus.mem_dat_i    <= mem[bus.mem_adr];
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          cyc;
    int          n_iss;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: ack/err cycle, issued byte addresses, read word, memory effect.
  task automatic model(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output int e_cyc, output logic e_err,
                       output logic [31:0] e_rd, output int e_n);
    logic [AW-3:0] word;
    logic [AW-1:0] ba;
    int            lane;
    word  = adr[AW-1:2];
    e_err = 1'b0;
`ifdef MEM_WB_BRIDGE_ERR_EN
    e_err = (adr[15:AW] != '0) || (sel == 4'h0);
`endif
    exp_iss.delete();
    e_rd = 32'h0;
    e_n  = 0;
    if (!e_err) begin
      for (int off = 0; off < 4; off++) begin
        lane = BE ? 3 - off : off;
        ba   = {word, 2'(off)};
        if (sel[lane]) begin
          exp_iss.push_back(ba);
          if (we) ref_mem[ba] = dat[8*lane +: 8];
          else    e_rd[8*lane +: 8] = ref_mem[ba];
          e_n++;
        end
      end
    end
    if (e_err || e_n == 0) e_cyc = 1;
    else if (we)           e_cyc = e_n + 1;
    else                   e_cyc = e_n + 2;
  endtask

  // Drive one request, log issued addresses, return the termination cycle (0 = none).
  task automatic xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int abort_after, output int done_cyc,
                      output logic got_err, output logic [31:0] rdat);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    iss_q.delete();
    done_cyc = 0;
    got_err  = 1'b0;
    rdat     = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_en) iss_q.push_back(bus.mem_adr);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        done_cyc = c;
        got_err  = bus.wb_err_o;
        rdat     = bus.wb_dat_o;
        break;
      end
      if (abort_after != 0 && iss_q.size() == abort_after) begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    if (done_cyc != 0) begin
      @(negedge clk);
      chk("term_pulse_width", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
    end
  endtask

  task automatic compare_model(input string tag, input logic we, input logic [15:0] adr,
                               input logic [3:0] sel, input logic [31:0] dat);
    int          e_cyc, e_n, d_cyc;
    logic        e_err, g_err;
    logic [31:0] e_rd, g_rd;
    model(we, adr, sel, dat, e_cyc, e_err, e_rd, e_n);
    xfer(we, adr, sel, dat, 0, d_cyc, g_err, g_rd);
    chk({tag, "_cyc"}, 32'(d_cyc), 32'(e_cyc));
    chk({tag, "_err"}, 32'(g_err), 32'(e_err));
    chk({tag, "_nissue"}, 32'(iss_q.size()), 32'(e_n));
    for (int k = 0; k < e_n && k < iss_q.size(); k++)
      chk({tag, "_issue_adr"}, 32'(iss_q[k]), 32'(exp_iss[k]));
    if (!we && !e_err) chk({tag, "_rdat"}, g_rd, e_rd);
    if (we) for (int k = 0; k < exp_iss.size(); k++)
      chk({tag, "_mem"}, 32'(mem[exp_iss[k]]), 32'(ref_mem[exp_iss[k]]));
  endtask

  initial begin
    int          e_cyc, e_n, d_cyc;
    logic        e_err, g_err;
    logic [31:0] e_rd, g_rd;
    logic        r_we;
    logic [1:0]  r_up;
    logic [15:0] r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;

    tbl[0] = '{1'b1, 16'h2000, 4'hF, 32'h11223344, 5, 4, 32'h0};
    tbl[1] = '{1'b0, 16'h2000, 4'hF, 32'h0,        6, 4, 32'h11223344};
    tbl[2] = '{1'b1, 16'h0100, 4'hF, 32'h40004240, 5, 4, 32'h0};
    tbl[3] = '{1'b0, 16'h0100, 4'h5, 32'h0,        4, 2, 32'h00000040};
    tbl[4] = '{1'b1, 16'h0204, 4'h8, 32'hAABBCCDD, 2, 1, 32'h0};
    tbl[5] = '{1'b0, 16'h0204, 4'hF, 32'h0,        6, 4, 32'hAA000000};
    tbl[6] = '{1'b0, 16'h0204, 4'h2, 32'h0,        3, 1, 32'h0};
    tbl[7] = '{1'b1, 16'h3FFC, 4'h3, 32'h12345678, 3, 2, 32'h0};
    tbl[8] = '{1'b0, 16'h3FFC, 4'hF, 32'h0,        6, 4, 32'h00005678};
    tbl[9] = '{1'b0, 16'h3FFC, 4'h1, 32'h0,        3, 1, 32'h00000078};

    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 16'h0;
    bus.wb_sel_i = 4'h0;
    bus.wb_dat_i = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ack",     32'(bus.wb_ack_o),  32'd0);
    chk("rst_err",     32'(bus.wb_err_o),  32'd0);
    chk("rst_mem_en",  32'(bus.mem_en),    32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),    32'd0);
    chk("rst_dat_o",   bus.wb_dat_o,       32'd0);
    chk("rst_mem_adr", 32'(bus.mem_adr),   32'd0);
    chk("rst_mem_dat", 32'(bus.mem_dat_o), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      model(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, e_cyc, e_err, e_rd, e_n);
      xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, 0, d_cyc, g_err, g_rd);
      chk($sformatf("vec%0d_cyc", i), 32'(d_cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d_nissue", i), 32'(iss_q.size()), 32'(tbl[i].n_iss));
      if (!tbl[i].we) chk($sformatf("vec%0d_rdat", i), g_rd, tbl[i].rd);
      if (i == 0) for (int k = 0; k < 4 && k < iss_q.size(); k++)
        chk("vec0_issue_order", 32'(iss_q[k]), 32'h2000 + 32'(k));
    end
    chk("be_byte0", 32'(mem[14'h2000]), 32'h11);
    chk("be_byte1", 32'(mem[14'h2001]), 32'h22);
    chk("be_byte2", 32'(mem[14'h2002]), 32'h33);
    chk("be_byte3", 32'(mem[14'h2003]), 32'h44);

    // Master drops the cycle after the second lane of a write.
    xfer(1'b1, 16'h0300, 4'hF, 32'hA1B2C3D4, 2, d_cyc, g_err, g_rd);
    chk("abort_no_ack", 32'(d_cyc), 32'd0);
    chk("abort_nissue", 32'(iss_q.size()), 32'd2);
    chk("abort_b0", 32'(mem[14'h0300]), 32'hA1);
    chk("abort_b1", 32'(mem[14'h0301]), 32'hB2);
    chk("abort_b2", 32'(mem[14'h0302]), 32'h00);
    chk("abort_b3", 32'(mem[14'h0303]), 32'h00);
    ref_mem[14'h0300] = 8'hA1;
    ref_mem[14'h0301] = 8'hB2;
    xfer(1'b0, 16'h0300, 4'hF, 32'h0, 0, d_cyc, g_err, g_rd);
    chk("after_abort_cyc",  32'(d_cyc), 32'd6);
    chk("after_abort_rdat", g_rd, 32'hA1B20000);

    // Reset lands in the third write-lane cycle.
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 16'h0400;
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_mem_en", 32'(bus.mem_en),   32'd0);
    chk("rst_mid_ack",    32'(bus.wb_ack_o), 32'd0);
    chk("rst_mid_adr",    32'(bus.mem_adr),  32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_b1", 32'(mem[14'h0401]), 32'hAD);
    chk("rst_mid_b2", 32'(mem[14'h0402]), 32'h00);
    ref_mem[14'h0400] = 8'hDE;
    ref_mem[14'h0401] = 8'hAD;
    xfer(1'b0, 16'h0400, 4'hF, 32'h0, 0, d_cyc, g_err, g_rd);
    chk("after_rst_cyc",  32'(d_cyc), 32'd6);
    chk("after_rst_rdat", g_rd, 32'hDEAD0000);

`ifdef MEM_WB_BRIDGE_ERR_EN
    xfer(1'b1, 16'h4000, 4'hF, 32'h5A5A1234, 0, d_cyc, g_err, g_rd);
    chk("err_adr_cyc",    32'(d_cyc), 32'd1);
    chk("err_adr_flag",   32'(g_err), 32'd1);
    chk("err_adr_nissue", 32'(iss_q.size()), 32'd0);
    xfer(1'b0, 16'h0010, 4'h0, 32'h0, 0, d_cyc, g_err, g_rd);
    chk("err_sel0_cyc",    32'(d_cyc), 32'd1);
    chk("err_sel0_flag",   32'(g_err), 32'd1);
    chk("err_sel0_nissue", 32'(iss_q.size()), 32'd0);
`else
    compare_model("alias_wr", 1'b1, 16'h4000, 4'hF, 32'h5A5A1234);
    xfer(1'b0, 16'h0000, 4'hF, 32'h0, 0, d_cyc, g_err, g_rd);
    chk("alias_rd_cyc",  32'(d_cyc), 32'd6);
    chk("alias_rd_rdat", g_rd, 32'h5A5A1234);
    xfer(1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF, 0, d_cyc, g_err, g_rd);
    chk("sel0_cyc",    32'(d_cyc), 32'd1);
    chk("sel0_err",    32'(g_err), 32'd0);
    chk("sel0_nissue", 32'(iss_q.size()), 32'd0);
`endif

    for (int t = 0; t < 300; t++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_sel = 4'($urandom_range(0, 15));
      r_up  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_adr = {r_up, 8'h00, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      r_dat = $urandom;
      compare_model($sformatf("rnd%0d", t), r_we, r_adr, r_sel, r_dat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

endmodule
